// File: rtl/credit_counter_pkg.sv
// Shared constants for the credit counter block.
// Holds only the default credit width; no types are exported.
package credit_counter_pkg;

   localparam int CC_DEFAULT_WIDTH = 4;

endpackage : credit_counter_pkg

// File: rtl/credit_counter_if.sv
// Signal bundle for driving and observing a credit_counter instance.
// master = the side that drives credits/config, slave = the counter's view.
interface credit_counter_if
   import credit_counter_pkg::*;
#(
   parameter int WIDTH = CC_DEFAULT_WIDTH
) (
   input logic clock
);

   logic             enable;
   logic             sim_time_tick;
   logic [WIDTH-1:0] config_in;
   logic             config_in_valid;
   logic [WIDTH-1:0] config_out;
   logic             config_out_valid;
   logic             credit_in_valid;
   logic             credit_ack;
   logic             decrement;
   logic [WIDTH-1:0] count_out;

   modport master (
      input  clock,
      output enable, sim_time_tick, config_in, config_in_valid,
             credit_in_valid, decrement,
      input  config_out, config_out_valid, credit_ack, count_out
   );

   modport slave (
      input  clock,
      input  enable, sim_time_tick, config_in, config_in_valid,
             credit_in_valid, decrement,
      output config_out, config_out_valid, credit_ack, count_out
   );

endinterface : credit_counter_if

// File: rtl/credit_counter.sv
// Credit counter: credits are consumed immediately, returned credits are
// staged in a pending register and committed on each simulation time tick.
module credit_counter
   import credit_counter_pkg::*;
#(
   parameter int WIDTH = CC_DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             sim_time_tick,
   input  logic [WIDTH-1:0] config_in,
   input  logic             config_in_valid,
   output logic [WIDTH-1:0] config_out,
   output logic             config_out_valid,
   input  logic             credit_in_valid,
   output logic             credit_ack,
   input  logic             decrement,
   output logic [WIDTH-1:0] count_out
);

   logic [WIDTH-1:0] max_credit_q, max_credit_d;
   logic [WIDTH-1:0] count_q,      count_d;
   logic [WIDTH-1:0] pending_q,    pending_d;
   logic [WIDTH-1:0] cfg_out_q,    cfg_out_d;
   logic             cfg_vld_q,    cfg_vld_d;

   logic [WIDTH:0]   commit_sum;
   logic [WIDTH-1:0] commit_cap;
   logic             dec_eff;

   // A config write wins the cycle, so it also suppresses the acknowledge.
   assign credit_ack = enable & credit_in_valid & ~config_in_valid
                       & (pending_q < max_credit_q);

   // Committed total is capped at the maximum before a same-cycle decrement.
   assign commit_sum = {1'b0, count_q} + {1'b0, pending_q};
   assign commit_cap = (commit_sum > {1'b0, max_credit_q}) ? max_credit_q
                                                             : commit_sum[WIDTH-1:0];

   always_comb begin
      max_credit_d = max_credit_q;
      count_d      = count_q;
      pending_d    = pending_q;
      cfg_out_d    = cfg_out_q;
      cfg_vld_d    = 1'b0;
      dec_eff      = 1'b0;

      if (config_in_valid) begin
         max_credit_d = config_in;
         count_d      = config_in;
         pending_d    = '0;
         cfg_out_d    = max_credit_q;
         cfg_vld_d    = 1'b1;
      end else if (enable) begin
         if (sim_time_tick) begin
            dec_eff   = decrement & (commit_cap != '0);
            count_d   = commit_cap - {{(WIDTH-1){1'b0}}, dec_eff};
            pending_d = credit_ack ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
         end else begin
            dec_eff = decrement & (count_q != '0);
            count_d = count_q - {{(WIDTH-1){1'b0}}, dec_eff};
            if (credit_ack) begin
               pending_d = pending_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         max_credit_q <= '0;
         count_q      <= '0;
         pending_q    <= '0;
         cfg_out_q    <= '0;
         cfg_vld_q    <= 1'b0;
      end else begin
         max_credit_q <= max_credit_d;
         count_q      <= count_d;
         pending_q    <= pending_d;
         cfg_out_q    <= cfg_out_d;
         cfg_vld_q    <= cfg_vld_d;
      end
   end

   assign count_out        = count_q;
   assign config_out       = cfg_out_q;
   assign config_out_valid = cfg_vld_q;

endmodule : credit_counter

// File: tb/tb_credit_counter.sv
// Scoreboard bench for credit_counter: a behavioural model predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_credit_counter;

   localparam int W = 4;

   typedef struct {
      int cnt;
      int cfg_out;
      int cfg_vld;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   credit_counter_if #(.WIDTH(W)) ccif (.clock(clock));

   credit_counter #(.WIDTH(W)) dut (
      .clock            (clock),
      .reset            (reset),
      .enable           (ccif.enable),
      .sim_time_tick    (ccif.sim_time_tick),
      .config_in        (ccif.config_in),
      .config_in_valid  (ccif.config_in_valid),
      .config_out       (ccif.config_out),
      .config_out_valid (ccif.config_out_valid),
      .credit_in_valid  (ccif.credit_in_valid),
      .credit_ack       (ccif.credit_ack),
      .decrement        (ccif.decrement),
      .count_out        (ccif.count_out)
   );

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb_q[$];

   int m_max = 0, m_cnt = 0, m_pend = 0, m_cfg_out = 0, m_cfg_vld = 0;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, check ack, predict, then compare registered outputs.
   task automatic step(input logic en, input logic dec, input logic civ,
                       input logic tick, input logic cfgv, input int cfg,
                       input logic rst, input int exp_cnt, input int exp_ack);
      int   m_ack;
      int   t;
      exp_t e;
      exp_t got;
      @(negedge clock);
      reset                = rst;
      ccif.enable          = en;
      ccif.decrement       = dec;
      ccif.credit_in_valid = civ;
      ccif.sim_time_tick   = tick;
      ccif.config_in_valid = cfgv;
      ccif.config_in       = cfg[W-1:0];
      #1;
      m_ack = (en && civ && !cfgv && (m_pend < m_max)) ? 1 : 0;
      check_eq("ack", int'(ccif.credit_ack), m_ack);
      if (exp_ack >= 0) check_eq("spec_ack", int'(ccif.credit_ack), exp_ack);

      if (rst) begin
         m_max = 0; m_cnt = 0; m_pend = 0; m_cfg_out = 0; m_cfg_vld = 0;
      end else if (cfgv) begin
         m_cfg_out = m_max;
         m_max     = cfg;
         m_cnt     = cfg;
         m_pend    = 0;
         m_cfg_vld = 1;
      end else begin
         m_cfg_vld = 0;
         if (en && tick) begin
            t = m_cnt + m_pend;
            if (t > m_max) t = m_max;
            if (dec && t > 0) t = t - 1;
            m_cnt  = t;
            m_pend = m_ack;
         end else if (en) begin
            if (dec && m_cnt > 0) m_cnt = m_cnt - 1;
            m_pend = m_pend + m_ack;
         end
      end
      e.cnt = m_cnt; e.cfg_out = m_cfg_out; e.cfg_vld = m_cfg_vld;
      sb_q.push_back(e);

      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 1, 0);
      end else begin
         got = sb_q.pop_front();
         check_eq("count_out", int'(ccif.count_out), got.cnt);
         check_eq("config_out", int'(ccif.config_out), got.cfg_out);
         check_eq("config_out_valid", int'(ccif.config_out_valid), got.cfg_vld);
      end
      if (exp_cnt >= 0) check_eq("spec_cnt", int'(ccif.count_out), exp_cnt);
   endtask

   initial begin
      reset                = 1'b1;
      ccif.enable          = 1'b0;
      ccif.decrement       = 1'b0;
      ccif.credit_in_valid = 1'b0;
      ccif.sim_time_tick   = 1'b0;
      ccif.config_in_valid = 1'b0;
      ccif.config_in       = '0;

      //   en dec civ tick cfgv cfg rst  cnt ack
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check_eq("rst_cfg_vld", int'(ccif.config_out_valid), 0);

      // Configure maximum of 5
      step(1, 0, 0, 0, 1, 5, 0, 5, 0);
      check_eq("spec_cfg_out", int'(ccif.config_out), 0);
      check_eq("spec_cfg_vld", int'(ccif.config_out_valid), 1);
      step(1, 0, 0, 0, 0, 0, 0, 5, 0);
      check_eq("spec_cfg_vld_drop", int'(ccif.config_out_valid), 0);

      // Use
      step(1, 1, 0, 0, 0, 0, 0, 4, 0);
      step(1, 1, 0, 0, 0, 0, 0, 3, 0);
      step(1, 1, 0, 0, 0, 0, 0, 2, 0);
      // Return then commit
      step(1, 0, 1, 0, 0, 0, 0, 2, 1);
      step(1, 0, 1, 0, 0, 0, 0, 2, 1);
      step(1, 0, 0, 1, 0, 0, 0, 4, 0);
      // Overlap
      step(1, 1, 1, 0, 0, 0, 0, 3, 1);
      step(1, 1, 0, 0, 0, 0, 0, 2, 0);
      step(1, 0, 0, 1, 0, 0, 0, 3, 0);
      // Drain to zero and hold there
      step(1, 1, 0, 0, 0, 0, 0, 2, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      // Fill pending to the maximum; the next return is refused
      for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0);
      // Disabled: everything ignored, including the tick
      step(0, 1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 5, 0);
      step(0, 1, 0, 0, 0, 0, 0, 5, 0);
      // Reset with pending and count both nonzero
      step(1, 0, 1, 0, 0, 0, 0, 5, 1);
      step(1, 1, 1, 0, 0, 0, 0, 4, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, -1);
      check_eq("spec_rst_cfg_out", int'(ccif.config_out), 0);
      check_eq("spec_rst_cfg_vld", int'(ccif.config_out_valid), 0);
      step(1, 0, 0, 1, 0, 0, 0, 0, 0);
      // Tick plus same-cycle ack and decrement after reconfiguration
      step(1, 0, 0, 0, 1, 7, 0, 7, 0);
      step(1, 1, 1, 0, 0, 0, 0, 6, 1);
      step(1, 1, 1, 1, 0, 0, 0, 6, 1);
      // Config overrides a same-cycle decrement/return/tick
      step(1, 1, 1, 1, 1, 3, 0, 3, 0);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 7) != 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 19) == 0,
              int'($urandom_range(0, (1 << W) - 1)),
              $urandom_range(0, 63) == 0,
              -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_credit_counter

// File: doc/credit_counter.md
CREDIT_COUNTER -- requirements
Module: credit_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of credit count, configured maximum and config word.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: when low, credit use/return and time ticks are ignored.
REQ-005 SHALL have port sim_time_tick, input, 1: one-cycle pulse marking a simulation time step; commits returned credits.
REQ-006 SHALL have port config_in, input, WIDTH: maximum credit value to load.
REQ-007 SHALL have port config_in_valid, input, 1: config_in qualifier.
REQ-008 SHALL have port config_out, output, WIDTH: previously held maximum, shifted out for daisy-chained configuration.
REQ-009 SHALL have port config_out_valid, output, 1: config_out qualifier.
REQ-010 SHALL have port credit_in_valid, input, 1: one credit returned by downstream this cycle.
REQ-011 SHALL have port credit_ack, output, 1: returned credit accepted this cycle.
REQ-012 SHALL have port decrement, input, 1: consume one credit this cycle.
REQ-013 SHALL have port count_out, output, WIDTH: currently available credits, registered.

Function
REQ-014 SHALL hold registers: max_credit, count, pending (returned credits not yet committed), config_out, config_out_valid.
REQ-015 On config_in_valid (regardless of enable): max_credit <= config_in; count <= config_in; pending <= 0; config_out <= old max_credit; config_out_valid <= 1 the next cycle.
REQ-016 config_out_valid SHALL be high only the cycle after a config_in_valid cycle; config_out holds its value otherwise.
REQ-017 config_in_valid SHALL take priority over decrement, credit_in_valid and sim_time_tick in the same cycle; those are dropped, and credit_ack is 0.
REQ-018 credit_ack SHALL be combinational: enable & credit_in_valid & ~config_in_valid & (pending < max_credit).
REQ-019 An acked credit SHALL increment pending by 1; count is unchanged until a tick.
REQ-020 When enable & sim_time_tick: count <= min(max_credit, count + pending) - dec_eff; pending <= (credit acked this cycle ? 1 : 0).
REQ-021 dec_eff SHALL be 1 when enable & decrement and the pre-subtraction value is nonzero, else 0; count never wraps below 0.
REQ-022 Without a tick, enable & decrement SHALL reduce count by 1 next cycle, saturating at 0.
REQ-023 Simultaneous decrement and acked credit without a tick: count -1 (saturating), pending +1.
REQ-024 Intermediate arithmetic SHALL use WIDTH+1 bits; count and pending never exceed max_credit.
REQ-025 When enable is low, count and pending SHALL hold, credit_ack = 0, and ticks have no effect.

Reset
REQ-026 Synchronous reset SHALL clear max_credit, count, pending, config_out and config_out_valid to 0, overriding all other inputs.
REQ-027 Reset mid-operation SHALL discard pending credits; count_out reads 0 the cycle after reset is sampled.

Structure
REQ-028 No shared package is required; WIDTH is the only parameter and no typedefs are exported.
REQ-029 Implementation SHALL be a single flat module with no sub-modules; saturating add/subtract logic lives inline.

Verification
REQ-030 Config: reset, then config_in=5 with config_in_valid for 1 cycle -> count_out=5; config_out=0 with config_out_valid=1 for one cycle.
REQ-031 Use: enable=1, decrement for 3 cycles -> count_out 4, 3, 2.
REQ-032 Return: credit_in_valid for 2 cycles -> credit_ack=1 each cycle, count_out stays 2; sim_time_tick -> count_out=4.
REQ-033 Overlap: credit_in_valid 1 cycle with decrement 2 cycles -> count_out 3 then 2; tick -> 3.
REQ-034 Boundaries: with count 0, decrement -> stays 0; with pending = max_credit, credit_in_valid -> credit_ack=0; with enable=0, all use/return/tick inputs are ignored.
REQ-035 Reset with pending>0 and count>0 -> all outputs 0; a following tick leaves count_out at 0.
